// File: rtl/spr_sched_pkg.sv
// Shared definitions for the per-scanline sprite scheduler.
// Latency: n/a (constants, types and one pure function).
// Backpressure: n/a.
//
// Contents: FSM state codes, OAM word field offsets, attribute bit
// positions, renderer load-word field positions, the slot record and
// the helper that packs a slot plus pattern row into a renderer word.
package spr_sched_pkg;

    // Top-level FSM state codes
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_EVAL        = 3'd1;
    localparam logic [2:0] ST_FETCH       = 3'd2;
    localparam logic [2:0] ST_LOAD_SETUP  = 3'd3;
    localparam logic [2:0] ST_LOAD_STROBE = 3'd4;
    localparam logic [2:0] ST_DONE        = 3'd5;

    // OAM entry field offsets (each field is 8 bits)
    localparam int OAM_Y_LSB    = 0;
    localparam int OAM_TILE_LSB = 8;
    localparam int OAM_ATTR_LSB = 16;
    localparam int OAM_X_LSB    = 24;

    // Bit positions inside the attribute byte
    localparam int ATTR_PAL_LSB = 0;
    localparam int ATTR_PRI     = 5;
    localparam int ATTR_HFLIP   = 6;
    localparam int ATTR_VFLIP   = 7;

    // Renderer load word field positions
    localparam int RB_PAT_LSB = 0;
    localparam int RB_X_LSB   = 16;
    localparam int RB_PAL_LSB = 24;
    localparam int RB_PRI     = 29;
    localparam int RB_HFLIP   = 30;

    typedef struct packed {
        logic [7:0] tile;
        logic [2:0] row;
        logic [7:0] x;
        logic [1:0] pal;
        logic       pri;
        logic       hflip;
    } slot_t;

    // Unused bits of the load word are forced to zero.
    function automatic logic [31:0] build_rend(input slot_t s, input logic [15:0] pat);
        logic [31:0] w;
        w                    = '0;
        w[RB_PAT_LSB +: 16]  = pat;
        w[RB_X_LSB   +: 8]   = s.x;
        w[RB_PAL_LSB +: 2]   = s.pal;
        w[RB_PRI]            = s.pri;
        w[RB_HFLIP]          = s.hflip;
        return w;
    endfunction

endpackage

// File: rtl/spr_sched_eval.sv
// OAM scan: walks all entries, keeps the first NUM_REND in range of the line.
// Latency: NUM_SPR+1 cycles from start to done, less on overflow.
// Backpressure: none; OAM is read one entry per cycle with fixed 1-cycle latency.
//
// Ports: start (restarts the scan, also while active), scanline (sampled
// on start), oam_addr/oam_data (synchronous OAM read), done (one-cycle,
// combinational, in the cycle of the last evaluation), any_slot (slot
// count after this cycle is non-zero), count/overflow/slots (results,
// stable from done until the next start).
module spr_eval
    import spr_sched_pkg::*;
#(
    parameter int NUM_SPR  = 64,
    parameter int NUM_REND = 8,
    parameter int SPR_H    = 8,
    localparam int AW = $clog2(NUM_SPR),
    localparam int CW = $clog2(NUM_REND + 1),
    localparam int SW = $clog2(NUM_REND)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             scanline,
    output logic [AW-1:0]          oam_addr,
    input  logic [31:0]            oam_data,
    output logic                   done,
    output logic                   any_slot,
    output logic [CW-1:0]          count,
    output logic                   overflow,
    output slot_t [NUM_REND-1:0]   slots
);

    logic       active;
    logic       addr_vld;   // oam_addr holds an entry still to be read
    logic       rd_vld;     // oam_data holds the entry addressed last cycle
    logic       rd_last;    // ... and that entry is the final one
    logic [7:0] line;
    logic [7:0] diff;
    logic [7:0] attr;
    logic       in_range;
    logic       hit_full;
    slot_t      new_slot;
    logic       unused_attr;

    assign attr     = oam_data[OAM_ATTR_LSB +: 8];
    assign diff     = line - oam_data[OAM_Y_LSB +: 8];   // wraps mod 256
    assign in_range = active && rd_vld && (diff < 8'(SPR_H));
    assign hit_full = in_range && (count == CW'(NUM_REND));
    assign done     = active && rd_vld && (rd_last || hit_full);
    assign any_slot = (count != '0) || (in_range && !hit_full);

    // 7 - r on three bits is the bitwise complement
    assign new_slot = '{
        tile:  oam_data[OAM_TILE_LSB +: 8],
        row:   attr[ATTR_VFLIP] ? ~diff[2:0] : diff[2:0],
        x:     oam_data[OAM_X_LSB +: 8],
        pal:   attr[ATTR_PAL_LSB +: 2],
        pri:   attr[ATTR_PRI],
        hflip: attr[ATTR_HFLIP]
    };

    // Attribute bits 4:2 carry nothing the renderer needs
    assign unused_attr = ^attr[4:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            addr_vld <= 1'b0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            oam_addr <= '0;
            count    <= '0;
            overflow <= 1'b0;
            line     <= '0;
        end else if (start) begin
            active   <= 1'b1;
            addr_vld <= 1'b1;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            oam_addr <= '0;
            count    <= '0;
            overflow <= 1'b0;
            line     <= scanline;
        end else if (active) begin
            rd_vld  <= addr_vld;
            rd_last <= addr_vld && (oam_addr == AW'(NUM_SPR - 1));
            if (addr_vld) begin
                if (oam_addr == AW'(NUM_SPR - 1)) begin
                    addr_vld <= 1'b0;
                end else begin
                    oam_addr <= oam_addr + 1'b1;
                end
            end
            if (in_range) begin
                if (hit_full) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (done) begin
                active   <= 1'b0;
                addr_vld <= 1'b0;
                rd_vld   <= 1'b0;
            end
        end
    end

    // Slot storage needs no reset: only slots below count are ever read
    always_ff @(posedge clk) begin
        if (!reset && !start && in_range && !hit_full) begin
            slots[count[SW-1:0]] <= new_slot;
        end
    end

endmodule

// File: rtl/spr_sched.sv
// Per-scanline sprite scheduler: selects, fetches and loads up to NUM_REND sprites.
// Latency: (NUM_SPR+1) + per sprite (fetch wait + 3) + 1 cycles from line_start.
// Backpressure: pattern fetch holds pat_req until pat_ack, waiting indefinitely.
//
// Ports: line_start/scanline start a line (also restart while busy);
// oam_addr/oam_data read OAM; pat_req/pat_tile/pat_row/pat_ack/pat_data
// fetch pattern rows; rend_buf + one-hot rend_now load the renderers;
// draw and sprite_overflow are published at the end of the line and held
// until the next line_start; busy is high outside IDLE.
module spr_sched
    import spr_sched_pkg::*;
#(
    parameter int NUM_SPR  = 64,
    parameter int NUM_REND = 8,
    parameter int SPR_H    = 8,
    localparam int AW = $clog2(NUM_SPR),
    localparam int CW = $clog2(NUM_REND + 1),
    localparam int SW = $clog2(NUM_REND)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                line_start,
    input  logic [7:0]          scanline,
    output logic [AW-1:0]       oam_addr,
    input  logic [31:0]         oam_data,
    output logic                pat_req,
    output logic [7:0]          pat_tile,
    output logic [2:0]          pat_row,
    input  logic                pat_ack,
    input  logic [15:0]         pat_data,
    output logic [31:0]         rend_buf,
    output logic [NUM_REND-1:0] rend_now,
    output logic [NUM_REND-1:0] draw,
    output logic                sprite_overflow,
    output logic                busy
);

    logic [2:0]            state;
    logic [CW-1:0]         k;
    logic                  eval_done;
    logic                  eval_any;
    logic [CW-1:0]         eval_count;
    logic                  eval_ovf;
    slot_t [NUM_REND-1:0]  eval_slots;
    slot_t                 cur;
    logic [NUM_REND-1:0]   draw_mask;

    spr_eval #(
        .NUM_SPR  (NUM_SPR),
        .NUM_REND (NUM_REND),
        .SPR_H    (SPR_H)
    ) u_eval (
        .clk      (clk),
        .reset    (reset),
        .start    (line_start),
        .scanline (scanline),
        .oam_addr (oam_addr),
        .oam_data (oam_data),
        .done     (eval_done),
        .any_slot (eval_any),
        .count    (eval_count),
        .overflow (eval_ovf),
        .slots    (eval_slots)
    );

    assign cur = eval_slots[k[SW-1:0]];

    // Request and strobe decode straight from the registered state, so a
    // restart or reset removes them in the very next cycle.
    assign pat_req  = (state == ST_FETCH);
    assign pat_tile = pat_req ? cur.tile : '0;
    assign pat_row  = pat_req ? cur.row  : '0;
    assign rend_now = (state == ST_LOAD_STROBE) ? (NUM_REND'(1) << k) : '0;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        draw_mask = '0;
        for (int i = 0; i < NUM_REND; i++) begin
            draw_mask[i] = (CW'(i) < eval_count);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            k               <= '0;
            rend_buf        <= '0;
            draw            <= '0;
            sprite_overflow <= 1'b0;
        end else if (line_start) begin
            // Any in-flight fetch is abandoned; a coincident pat_ack is dropped
            state           <= ST_EVAL;
            k               <= '0;
            draw            <= '0;
            sprite_overflow <= 1'b0;
        end else begin
            case (state)
                ST_EVAL: begin
                    if (eval_done) begin
                        k     <= '0;
                        state <= eval_any ? ST_FETCH : ST_DONE;
                    end
                end
                ST_FETCH: begin
                    if (pat_ack) begin
                        rend_buf <= build_rend(cur, pat_data);
                        state    <= ST_LOAD_SETUP;
                    end
                end
                ST_LOAD_SETUP: begin
                    state <= ST_LOAD_STROBE;
                end
                ST_LOAD_STROBE: begin
                    if ((k + 1'b1) < eval_count) begin
                        k     <= k + 1'b1;
                        state <= ST_FETCH;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    draw            <= draw_mask;
                    sprite_overflow <= eval_ovf;
                    state           <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spr_sched.sv
// Directed bench for spr_sched: single-sprite vector table plus line-level
// sequences (overflow, empty line timing, restart while loading, reset
// during fetch). OAM and pattern memory are modelled in the bench.
module tb_spr_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [7:0]  scanline;
    logic [5:0]  oam_addr;
    logic [31:0] oam_data;
    logic        pat_req;
    logic [7:0]  pat_tile;
    logic [2:0]  pat_row;
    logic        pat_ack = 1'b0;
    logic [15:0] pat_data = 16'h0;
    logic [31:0] rend_buf;
    logic [7:0]  rend_now;
    logic [7:0]  draw;
    logic        sprite_overflow;
    logic        busy;

    always #5 clk = ~clk;

    spr_sched dut (
        .clk             (clk),
        .reset           (reset),
        .line_start      (line_start),
        .scanline        (scanline),
        .oam_addr        (oam_addr),
        .oam_data        (oam_data),
        .pat_req         (pat_req),
        .pat_tile        (pat_tile),
        .pat_row         (pat_row),
        .pat_ack         (pat_ack),
        .pat_data        (pat_data),
        .rend_buf        (rend_buf),
        .rend_now        (rend_now),
        .draw            (draw),
        .sprite_overflow (sprite_overflow),
        .busy            (busy)
    );

    // OAM model: synchronous read, data one cycle after the address
    logic [31:0] oam [64];
    always @(posedge clk) oam_data <= oam[oam_addr];

    // Pattern memory model: acks after ack_dly waiting cycles
    int ack_dly     = 2;
    bit pat_by_tile = 1'b0;
    int wait_cnt    = 0;
    always @(negedge clk) begin
        if (pat_ack) begin
            pat_ack  = 1'b0;
            wait_cnt = 0;
        end else if (pat_req) begin
            if (wait_cnt >= ack_dly) begin
                pat_ack  = 1'b1;
                pat_data = pat_by_tile ? {pat_tile, 8'h5A} : 16'hA5C3;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Monitor: one record per new fetch request and per load strobe
    logic        req_prev = 1'b0;
    logic [7:0]  req_tile [$];
    logic [2:0]  req_row  [$];
    logic [7:0]  stb_now  [$];
    logic [31:0] stb_buf  [$];
    always @(negedge clk) begin
        if (pat_req && !req_prev) begin
            req_tile.push_back(pat_tile);
            req_row.push_back(pat_row);
        end
        req_prev = pat_req;
        if (rend_now != 8'h00) begin
            stb_now.push_back(rend_now);
            stb_buf.push_back(rend_buf);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_tile.delete();
        req_row.delete();
        stb_now.delete();
        stb_buf.delete();
    endtask

    // Returns just after the edge that samples line_start
    task automatic start_line(input logic [7:0] sl);
        scanline   = sl;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Every entry placed 128 lines away from sl, so none is in range
    task automatic fill_off(input logic [7:0] sl);
        logic [7:0] y;
        y = sl + 8'd128;
        for (int i = 0; i < 64; i++) oam[i] = {24'h0, y};
    endtask

    // Ten sprites at Y=50 in entries 0..9, tile 0x30+i, X=8*i, palette i%4
    task automatic fill_ten();
        fill_off(8'd55);
        for (int i = 0; i < 10; i++) begin
            oam[i] = {8'(i * 8), {6'b0, 2'(i)}, 8'(8'h30 + i), 8'd50};
        end
    endtask

    typedef struct {
        int         idx;
        logic [7:0] y;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
        logic [7:0] sl;
        bit         hit;
        logic [2:0] row;
        logic [15:0] hi;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{0,  8'd10,  8'h22, 8'h00, 8'd40,  8'd12,  1'b1, 3'd2, 16'h0028};
        vt[1] = '{0,  8'd10,  8'h22, 8'hC3, 8'd40,  8'd12,  1'b1, 3'd5, 16'h4328};
        vt[2] = '{5,  8'd250, 8'h11, 8'h00, 8'h00,  8'd2,   1'b0, 3'd0, 16'h0000};
        vt[3] = '{63, 8'd251, 8'h44, 8'h00, 8'h10,  8'd2,   1'b1, 3'd7, 16'h0010};
        vt[4] = '{17, 8'd100, 8'h55, 8'h20, 8'hFF,  8'd107, 1'b1, 3'd7, 16'h20FF};
        vt[5] = '{17, 8'd100, 8'h55, 8'h00, 8'h00,  8'd108, 1'b0, 3'd0, 16'h0000};
        vt[6] = '{31, 8'd0,   8'h66, 8'h80, 8'h00,  8'd0,   1'b1, 3'd7, 16'h0000};
        vt[7] = '{2,  8'd5,   8'h77, 8'h00, 8'h00,  8'd3,   1'b0, 3'd0, 16'h0000};

        // Reset, held together with line_start: reset must win
        reset      = 1'b1;
        line_start = 1'b1;
        scanline   = 8'd12;
        fill_off(8'd12);
        repeat (3) tick();
        check("rst busy",     32'(busy),            32'd0);
        check("rst pat_req",  32'(pat_req),         32'd0);
        check("rst rend_now", 32'(rend_now),        32'd0);
        check("rst rend_buf", rend_buf,             32'd0);
        check("rst draw",     32'(draw),            32'd0);
        check("rst ovf",      32'(sprite_overflow), 32'd0);
        check("rst oam_addr", 32'(oam_addr),        32'd0);
        reset      = 1'b0;
        line_start = 1'b0;
        tick();
        check("post-rst busy", 32'(busy), 32'd0);

        // Single-sprite vectors
        ack_dly     = 2;
        pat_by_tile = 1'b0;
        for (int v = 0; v < 8; v++) begin
            fill_off(vt[v].sl);
            oam[vt[v].idx] = {vt[v].x, vt[v].attr, vt[v].tile, vt[v].y};
            clear_logs();
            start_line(vt[v].sl);
            wait_idle($sformatf("v%0d timeout", v));
            check($sformatf("v%0d nreq", v), 32'(req_tile.size()), 32'(vt[v].hit));
            check($sformatf("v%0d nstb", v), 32'(stb_now.size()),  32'(vt[v].hit));
            if (vt[v].hit) begin
                check($sformatf("v%0d tile", v),     32'(req_tile[0]), 32'(vt[v].tile));
                check($sformatf("v%0d row", v),      32'(req_row[0]),  32'(vt[v].row));
                check($sformatf("v%0d rend_now", v), 32'(stb_now[0]),  32'h01);
                check($sformatf("v%0d rend_buf", v), stb_buf[0],       {vt[v].hi, 16'hA5C3});
            end
            check($sformatf("v%0d draw", v), 32'(draw),            32'(vt[v].hit));
            check($sformatf("v%0d ovf", v),  32'(sprite_overflow), 32'd0);
        end

        // Empty line: DONE in the cycle 66 after line_start, idle one later
        fill_off(8'd10);
        clear_logs();
        start_line(8'd10);
        check("empty oam_addr0", 32'(oam_addr), 32'd0);
        tick();
        check("empty oam_addr1", 32'(oam_addr), 32'd1);
        repeat (64) tick();
        check("empty busy in DONE", 32'(busy), 32'd1);
        tick();
        check("empty busy idle", 32'(busy),            32'd0);
        check("empty draw",      32'(draw),            32'd0);
        check("empty ovf",       32'(sprite_overflow), 32'd0);
        check("empty nreq",      32'(req_tile.size()), 32'd0);

        // Ten in range: first eight loaded in OAM order, overflow flagged
        fill_ten();
        pat_by_tile = 1'b1;
        clear_logs();
        start_line(8'd55);
        wait_idle("ten timeout");
        check("ten nreq", 32'(req_tile.size()), 32'd8);
        check("ten nstb", 32'(stb_now.size()),  32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ten tile%0d", i), 32'(req_tile[i]), 32'(8'h30 + i));
            check($sformatf("ten row%0d", i),  32'(req_row[i]),  32'd5);
            check($sformatf("ten now%0d", i),  32'(stb_now[i]),  32'(8'h01 << i));
            check($sformatf("ten buf%0d", i),  stb_buf[i],
                  {6'b0, 2'(i), 8'(i * 8), 8'(8'h30 + i), 8'h5A});
        end
        check("ten draw", 32'(draw),            32'hFF);
        check("ten ovf",  32'(sprite_overflow), 32'd1);

        // Restart with line_start while slot 1 is in LOAD_SETUP
        clear_logs();
        start_line(8'd55);
        for (int n = 0; n < 500; n++) begin
            tick();
            if (req_tile.size() == 2 && !pat_req) break;
        end
        check("restart reached load", 32'(req_tile.size() == 2 && !pat_req), 32'd1);
        start_line(8'd200);
        check("restart draw",     32'(draw),     32'd0);
        check("restart ovf",      32'(sprite_overflow), 32'd0);
        check("restart busy",     32'(busy),     32'd1);
        check("restart oam_addr", 32'(oam_addr), 32'd0);
        check("restart rend_now", 32'(rend_now), 32'd0);
        tick();
        check("restart oam_addr1", 32'(oam_addr), 32'd1);
        wait_idle("restart timeout");
        check("restart nstb", 32'(stb_now.size()),  32'd1);
        check("restart nreq", 32'(req_tile.size()), 32'd2);
        check("restart draw end", 32'(draw),        32'd0);

        // Reset while fetching slot 3
        ack_dly = 5;
        clear_logs();
        start_line(8'd55);
        for (int n = 0; n < 500; n++) begin
            tick();
            if (req_tile.size() == 4 && pat_req) break;
        end
        check("fetch3 reached", 32'(req_tile.size() == 4 && pat_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst busy",     32'(busy),            32'd0);
        check("midrst pat_req",  32'(pat_req),         32'd0);
        check("midrst pat_tile", 32'(pat_tile),        32'd0);
        check("midrst pat_row",  32'(pat_row),         32'd0);
        check("midrst rend_buf", rend_buf,             32'd0);
        check("midrst rend_now", 32'(rend_now),        32'd0);
        check("midrst draw",     32'(draw),            32'd0);
        check("midrst ovf",      32'(sprite_overflow), 32'd0);
        check("midrst oam_addr", 32'(oam_addr),        32'd0);
        repeat (20) tick();
        check("midrst nstb", 32'(stb_now.size()),  32'd3);
        check("midrst nreq", 32'(req_tile.size()), 32'd4);
        check("midrst idle", 32'(busy),            32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
